// File: rtl/pwm_bank_if.sv
// Configuration write bus and per-channel PWM status for pwm_bank.
// The register-file side uses master; the PWM bank uses slave.
interface pwm_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIV_W  = 8
);
  logic [NUM_CH-1:0]       cfg_we;
  logic [NUM_CH*CNT_W-1:0] cfg_high;
  logic [NUM_CH*CNT_W-1:0] cfg_top;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic [NUM_CH*3-1:0]     cfg_mode;
  logic [NUM_CH-1:0]       pwm_out;
  logic [NUM_CH-1:0]       period_done;
  logic [NUM_CH-1:0]       upd_pending;

  modport master (
    output cfg_we, cfg_high, cfg_top, cfg_div, cfg_mode,
    input  pwm_out, period_done, upd_pending
  );

  modport slave (
    input  cfg_we, cfg_high, cfg_top, cfg_div, cfg_mode,
    output pwm_out, period_done, upd_pending
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with prescaler, edge/centre alignment, inversion
// and shadowed configuration that takes effect only at a period boundary.
module pwm_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic      clock,
  input  logic      reset,
  pwm_bank_if.slave bus
);

  localparam int unsigned MODE_W = 3;
  localparam logic [0:0]  DIR_UP = 1'b0;
  localparam logic [0:0]  DIR_DN = 1'b1;

  typedef struct packed {
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] top;
    logic [DIV_W-1:0] div;
    logic             en;
    logic             inv;
    logic             centre;
  } cfg_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cfg_t             wr_c;
    cfg_t             act_q;
    cfg_t             act_d;
    cfg_t             pend_q;
    cfg_t             pend_d;
    logic             pend_v_q;
    logic             pend_v_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [0:0]       dir_q;
    logic [0:0]       dir_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             done_q;
    logic             done_d;
    logic             run_c;
    logic             tick_c;
    logic             bnd_c;

    // This channel's slice of the write bus.
    always_comb begin
      wr_c        = '0;
      wr_c.high   = bus.cfg_high[g*CNT_W +: CNT_W];
      wr_c.top    = bus.cfg_top[g*CNT_W +: CNT_W];
      wr_c.div    = bus.cfg_div[g*DIV_W +: DIV_W];
      {wr_c.en, wr_c.inv, wr_c.centre} = bus.cfg_mode[g*MODE_W +: MODE_W];
    end

    // Prescaler tick and period boundary detection.
    always_comb begin
      run_c  = act_q.en && (act_q.div != '0);
      tick_c = run_c && (div_cnt_q == act_q.div - DIV_W'(1));
      bnd_c  = 1'b0;
      if (act_q.centre) begin
        bnd_c = tick_c && ((act_q.top == '0) || ((cnt_q == '0) && (dir_q == DIR_DN)));
      end else begin
        bnd_c = tick_c && (cnt_q >= act_q.top);
      end
    end

    // Counter, direction and prescaler next state.
    always_comb begin
      cnt_d     = cnt_q;
      div_cnt_d = div_cnt_q;
      dir_d     = dir_q;
      if (!run_c) begin
        cnt_d     = '0;
        div_cnt_d = '0;
        dir_d     = DIR_UP;
      end else if (!tick_c) begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end else begin
        div_cnt_d = '0;
        if (!act_q.centre) begin
          dir_d = DIR_UP;
          cnt_d = (cnt_q >= act_q.top) ? '0 : cnt_q + CNT_W'(1);
        end else if (act_q.top == '0) begin
          dir_d = DIR_UP;
          cnt_d = '0;
        end else if (dir_q == DIR_UP) begin
          if (cnt_q >= act_q.top) begin
            dir_d = DIR_DN;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            dir_d = DIR_UP;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    end

    // Shadow register: a write on a boundary cycle bypasses straight to active.
    always_comb begin
      act_d    = act_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      if (pend_v_q && (bnd_c || !run_c)) begin
        act_d    = pend_q;
        pend_v_d = 1'b0;
      end
      if (bus.cfg_we[g]) begin
        if (bnd_c) begin
          act_d    = wr_c;
          pend_v_d = 1'b0;
        end else begin
          pend_d   = wr_c;
          pend_v_d = 1'b1;
        end
      end
    end

    // Compare stage; an idle channel parks at its inversion level.
    always_comb begin
      pwm_d  = act_q.inv;
      done_d = bnd_c;
      if (run_c) begin
        pwm_d = (cnt_q < act_q.high) ^ act_q.inv;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        act_q     <= '0;
        pend_q    <= '0;
        pend_v_q  <= 1'b0;
        cnt_q     <= '0;
        div_cnt_q <= '0;
        dir_q     <= DIR_UP;
        pwm_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        act_q     <= act_d;
        pend_q    <= pend_d;
        pend_v_q  <= pend_v_d;
        cnt_q     <= cnt_d;
        div_cnt_q <= div_cnt_d;
        dir_q     <= dir_d;
        pwm_q     <= pwm_d;
        done_q    <= done_d;
      end
    end

    assign bus.pwm_out[g]     = pwm_q;
    assign bus.period_done[g] = done_q;
    assign bus.upd_pending[g] = pend_v_q;
  end

endmodule
